// File: rtl/axi_fifo_bridge_v2.sv
// AXI4-Lite slave bridging the PS to the VLC encoder/decoder byte streams through two async FIFOs.
// Define AXI_FIFO_BRIDGE_CNT_EN to add the TXCNT (0x14) / RXCNT (0x18) push/pop counters.

module async_fifo_core #(
    parameter int DW      = 8,
    parameter int PTR     = 11,
    parameter int TIMEOUT = 32,
    parameter int OVERRUN = 1024
) (
    input  logic          wclk,
    input  logic          wrst_n,
    input  logic          winc,
    input  logic [DW-1:0] wdata,
    output logic          wfull,
    input  logic          rclk,
    input  logic          rrst_n,
    input  logic          rinc,
    output logic [DW-1:0] rdata,
    output logic          rempty,
    output logic          roverrun,
    output logic          rtout
);
    localparam logic [31:0] TOUT_L = TIMEOUT;
    localparam logic [31:0] OVR_L  = OVERRUN;

    logic [DW-1:0] mem [2**PTR];
    logic [PTR:0]  wbin_q, wgray_q, wq1_rgray_q, wq2_rgray_q, wbin_d, wgray_d;
    logic [PTR:0]  rbin_q, rgray_q, rq1_wgray_q, rq2_wgray_q, rbin_d, rgray_d, rlevel;
    logic          wfull_q, rempty_q, rovr_q;
    logic [31:0]   tout_cnt_q;

    function automatic logic [PTR:0] gray2bin(input logic [PTR:0] g);
        logic [PTR:0] b;
        b[PTR] = g[PTR];
        for (int i = PTR - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign wbin_d  = wbin_q + {{PTR{1'b0}}, winc & ~wfull_q};
    assign wgray_d = (wbin_d >> 1) ^ wbin_d;
    assign rbin_d  = rbin_q + {{PTR{1'b0}}, rinc & ~rempty_q};
    assign rgray_d = (rbin_d >> 1) ^ rbin_d;
    assign rlevel  = gray2bin(rq2_wgray_q) - rbin_q;

    always_ff @(posedge wclk) begin
        if (winc && !wfull_q) mem[wbin_q[PTR-1:0]] <= wdata;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q      <= '0;
            wgray_q     <= '0;
            wq1_rgray_q <= '0;
            wq2_rgray_q <= '0;
            wfull_q     <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            wgray_q     <= wgray_d;
            wq1_rgray_q <= rgray_q;
            wq2_rgray_q <= wq1_rgray_q;
            wfull_q     <= (wgray_d == {~wq2_rgray_q[PTR:PTR-1], wq2_rgray_q[PTR-2:0]});
        end
    end

    // Overrun is a fill-level threshold; timeout counts read cycles a non-empty FIFO goes unserviced.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            rq1_wgray_q <= '0;
            rq2_wgray_q <= '0;
            rempty_q    <= 1'b1;
            rovr_q      <= 1'b0;
            tout_cnt_q  <= '0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            rq1_wgray_q <= wgray_q;
            rq2_wgray_q <= rq1_wgray_q;
            rempty_q    <= (rgray_d == rq2_wgray_q);
            rovr_q      <= (32'(rlevel) >= OVR_L);
            if (rempty_q || rinc)          tout_cnt_q <= '0;
            else if (tout_cnt_q != TOUT_L) tout_cnt_q <= tout_cnt_q + 32'd1;
        end
    end

    assign wfull    = wfull_q;
    assign rempty   = rempty_q;
    assign rdata    = mem[rbin_q[PTR-1:0]];
    assign roverrun = rovr_q;
    assign rtout    = (tout_cnt_q == TOUT_L);
endmodule

module axi_fifo_bridge_v2 #(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter int          DATA_W       = 8,
    parameter int          FIFO_PTR     = 11,
    parameter int          FIFO_TIMEOUT = 32,
    parameter int          FIFO_OVERRUN = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [31:0]       s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              irq,
    input  logic              pclk,
    input  logic              fifo_resetn,
    input  logic              tx_rinc,
    output logic [DATA_W-1:0] tx_rdata,
    output logic              tx_rempty,
    input  logic              rx_winc,
    input  logic [DATA_W-1:0] rx_wdata,
    output logic              rx_wfull
);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t    w_state_q;
    r_state_t    r_state_q;
    logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q, irq_q;
    logic [1:0]  bresp_q, rresp_q, w_resp, r_resp;
    logic [31:0] rdata_q, r_word;
    logic [3:0]  irq_en_q, irq_stat_q, irq_stat_d, stat_set, stat_clr;
    logic        rx_empty_prev_q, ovr_prev_q, tout_prev_q;
    logic        tx_winc, tx_wfull, rx_rinc, rx_rempty, rx_overrun, rx_tout;
    logic        w_act, w_hit, r_hit, tx_try, tx_ovf;
    logic [4:0]  w_off, r_off;
    logic [DATA_W-1:0] rx_rdata;
    logic        unused_ok;

    async_fifo_core #(.DW(DATA_W), .PTR(FIFO_PTR), .TIMEOUT(FIFO_TIMEOUT), .OVERRUN(FIFO_OVERRUN)) u_tx (
        .wclk(aclk), .wrst_n(fifo_resetn), .winc(tx_winc), .wdata(s_wdata[DATA_W-1:0]), .wfull(tx_wfull),
        .rclk(pclk), .rrst_n(fifo_resetn), .rinc(tx_rinc), .rdata(tx_rdata), .rempty(tx_rempty),
        .roverrun(), .rtout()
    );

    async_fifo_core #(.DW(DATA_W), .PTR(FIFO_PTR), .TIMEOUT(FIFO_TIMEOUT), .OVERRUN(FIFO_OVERRUN)) u_rx (
        .wclk(pclk), .wrst_n(fifo_resetn), .winc(rx_winc), .wdata(rx_wdata), .wfull(rx_wfull),
        .rclk(aclk), .rrst_n(fifo_resetn), .rinc(rx_rinc), .rdata(rx_rdata), .rempty(rx_rempty),
        .roverrun(rx_overrun), .rtout(rx_tout)
    );

    assign w_act   = (w_state_q == W_ACK);
    assign w_hit   = (s_awaddr[31:5] == BASE_ADDR[31:5]);
    assign w_off   = s_awaddr[4:0];
    assign r_hit   = (s_araddr[31:5] == BASE_ADDR[31:5]);
    assign r_off   = s_araddr[4:0];
    assign tx_try  = w_act && w_hit && (w_off == 5'h00) && s_wstrb[0];
    assign tx_winc = tx_try && !tx_wfull;
    assign tx_ovf  = tx_try && tx_wfull;
    assign rx_rinc = (r_state_q == R_ACK) && r_hit && (r_off == 5'h04) && !rx_rempty;

`ifdef AXI_FIFO_BRIDGE_CNT_EN
    logic [31:0] txcnt_q, rxcnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            txcnt_q <= '0;
            rxcnt_q <= '0;
        end else begin
            if (w_act && w_hit && w_off == 5'h14) txcnt_q <= '0;
            else if (tx_winc)                     txcnt_q <= txcnt_q + 32'd1;
            if (w_act && w_hit && w_off == 5'h18) rxcnt_q <= '0;
            else if (rx_rinc)                     rxcnt_q <= rxcnt_q + 32'd1;
        end
    end
`endif

    always_comb begin
        w_resp = DECERR;
        if (w_hit) begin
            case (w_off)
                5'h00:        w_resp = tx_ovf ? SLVERR : OKAY;
                5'h04, 5'h08: w_resp = SLVERR;
                5'h0C, 5'h10: w_resp = OKAY;
`ifdef AXI_FIFO_BRIDGE_CNT_EN
                5'h14, 5'h18: w_resp = OKAY;
`endif
                default:      w_resp = DECERR;
            endcase
        end
    end

    always_comb begin
        r_resp = DECERR;
        r_word = '0;
        if (r_hit) begin
            case (r_off)
                5'h00: r_resp = SLVERR;
                5'h04: begin
                    r_resp = rx_rempty ? SLVERR : OKAY;
                    r_word = rx_rempty ? 32'd0 : 32'(rx_rdata);
                end
                5'h08: begin
                    r_resp = OKAY;
                    r_word = {28'd0, rx_tout, rx_overrun, tx_wfull, rx_rempty};
                end
                5'h0C: begin r_resp = OKAY; r_word = {28'd0, irq_en_q};   end
                5'h10: begin r_resp = OKAY; r_word = {28'd0, irq_stat_q}; end
`ifdef AXI_FIFO_BRIDGE_CNT_EN
                5'h14: begin r_resp = OKAY; r_word = txcnt_q; end
                5'h18: begin r_resp = OKAY; r_word = rxcnt_q; end
`endif
                default: r_resp = DECERR;
            endcase
        end
    end

    // Set beats clear so an event landing on a W1C write is never lost.
    assign stat_set   = {tx_ovf, rx_tout & ~tout_prev_q, rx_overrun & ~ovr_prev_q, rx_empty_prev_q & ~rx_rempty};
    assign stat_clr   = (w_act && w_hit && w_off == 5'h10 && s_wstrb[0]) ? s_wdata[3:0] : 4'h0;
    assign irq_stat_d = (irq_stat_q & ~stat_clr) | stat_set;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: if (s_awvalid && s_wvalid) begin
                    w_state_q <= W_ACK;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                end
                W_ACK: begin
                    w_state_q <= W_RESP;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    bresp_q   <= w_resp;
                end
                W_RESP: if (s_bready) begin
                    w_state_q <= W_IDLE;
                    bvalid_q  <= 1'b0;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: if (s_arvalid) begin
                    r_state_q <= R_ACK;
                    arready_q <= 1'b1;
                end
                R_ACK: begin
                    r_state_q <= R_DATA;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b1;
                    rresp_q   <= r_resp;
                    rdata_q   <= r_word;
                end
                R_DATA: if (s_rready) begin
                    r_state_q <= R_IDLE;
                    rvalid_q  <= 1'b0;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_en_q        <= '0;
            irq_stat_q      <= '0;
            irq_q           <= 1'b0;
            rx_empty_prev_q <= 1'b1;
            ovr_prev_q      <= 1'b0;
            tout_prev_q     <= 1'b0;
        end else begin
            if (w_act && w_hit && w_off == 5'h0C && s_wstrb[0]) irq_en_q <= s_wdata[3:0];
            irq_stat_q      <= irq_stat_d;
            irq_q           <= |(irq_stat_q & irq_en_q);
            rx_empty_prev_q <= rx_rempty;
            ovr_prev_q      <= rx_overrun;
            tout_prev_q     <= rx_tout;
        end
    end

    assign unused_ok = &{1'b0, s_wdata, s_wstrb};

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign irq       = irq_q;
endmodule

// File: tb/tb_axi_fifo_bridge_v2.sv
// Directed bench for axi_fifo_bridge_v2: AXI handshakes, FIFO paths, IRQ, decode errors and reset.
`timescale 1ns/1ps
module tb_axi_fifo_bridge_v2;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        aclk = 0, pclk = 0, aresetn = 0, fifo_resetn = 0;
    logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
    logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0;
    logic [3:0]  s_wstrb = 0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, irq;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic        tx_rinc = 0, rx_winc = 0, tx_rempty, rx_wfull;
    logic [7:0]  tx_rdata, rx_wdata = 0;

    int total = 0;
    int bad = 0;
    logic [1:0]  resp;
    logic [31:0] rd;
    int          errs;

    always #5 aclk = ~aclk;
    always #7 pclk = ~pclk;

    axi_fifo_bridge_v2 dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .irq(irq), .pclk(pclk), .fifo_resetn(fifo_resetn),
        .tx_rinc(tx_rinc), .tx_rdata(tx_rdata), .tx_rempty(tx_rempty),
        .rx_winc(rx_winc), .rx_wdata(rx_wdata), .rx_wfull(rx_wfull)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic acyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int hold, input bit verbose, output logic [1:0] r);
        int n = 0;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1; s_wvalid = 1;
        while (!(s_awready && s_wready) && n < 20) begin @(posedge aclk); #1; n++; end
        if (verbose) chk("wr_awready", {31'd0, s_awready & s_wready}, 32'd1);
        @(posedge aclk); #1;
        s_awvalid = 0; s_wvalid = 0;
        if (verbose) chk("wr_ready_1cyc_bvalid", {29'd0, s_awready, s_wready, s_bvalid}, 32'd1);
        r = s_bresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            chk("wr_hold", {29'd0, s_bvalid, s_bresp}, {29'd0, 1'b1, r});
        end
        s_bready = 1;
        @(posedge aclk); #1;
        s_bready = 0;
        if (verbose) $display("write addr=%h data=%h strb=%h bresp=%0d", addr, data, strb, r);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        s_araddr = addr; s_arvalid = 1;
        while (!s_arready && n < 20) begin @(posedge aclk); #1; n++; end
        chk("rd_arready", {31'd0, s_arready}, 32'd1);
        @(posedge aclk); #1;
        s_arvalid = 0;
        chk("rd_rvalid", {30'd0, s_arready, s_rvalid}, 32'd1);
        d = s_rdata; r = s_rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            chk("rd_hold", {s_rdata[30:0], s_rvalid} ^ {d[30:0], 1'b1}, 32'd0);
            chk("rd_hold_resp", {30'd0, s_rresp}, {30'd0, r});
        end
        s_rready = 1;
        @(posedge aclk); #1;
        s_rready = 0;
        $display("read  addr=%h rdata=%h rresp=%0d", addr, d, r);
    endtask

    task automatic rx_push(input logic [7:0] v);
        @(posedge pclk); #1;
        rx_winc = 1; rx_wdata = v;
        @(posedge pclk); #1;
        rx_winc = 0;
        $display("rx push data=%h", v);
    endtask

    task automatic tx_pop();
        @(posedge pclk); #1;
        tx_rinc = 1;
        @(posedge pclk); #1;
        tx_rinc = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        acyc(4);
        chk("rst_valid_ready", {26'd0, s_awready, s_wready, s_bvalid, s_arready, s_rvalid, irq}, 32'd0);
        chk("rst_resp_data", {s_rdata[27:0], s_bresp, s_rresp}, 32'd0);
        aresetn = 1; fifo_resetn = 1;
        acyc(4);
        chk("rst_tx_empty", {31'd0, tx_rempty}, 32'd1);

        // TXDATA write reaches pclk side
        axi_write(BASE, 32'h0000_00A5, 4'hF, 0, 1, resp);
        chk("tx_bresp", {30'd0, resp}, 32'd0);
        repeat (6) @(posedge pclk);
        #1;
        chk("tx_rempty_fall", {31'd0, tx_rempty}, 32'd0);
        chk("tx_rdata", {24'd0, tx_rdata}, 32'h0000_00A5);

        // RX push raises IRQ_STAT[0]; read pops it; W1C drops irq
        rx_push(8'h3C);
        acyc(6);
        axi_write(BASE + 32'h0C, 32'h1, 4'hF, 0, 1, resp);
        axi_read(BASE + 32'h10, 0, rd, resp);
        chk("irq_stat_rx", rd, 32'h1);
        chk("irq_high", {31'd0, irq}, 32'd1);
        axi_read(BASE + 32'h04, 0, rd, resp);
        chk("rx_rdata", rd, 32'h3C);
        chk("rx_rresp", {30'd0, resp}, 32'd0);
        axi_write(BASE + 32'h10, 32'h1, 4'hF, 0, 1, resp);
        acyc(1);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        // RXDATA read while empty
        axi_read(BASE + 32'h04, 0, rd, resp);
        chk("rx_empty_rdata", rd, 32'h0);
        chk("rx_empty_rresp", {30'd0, resp}, 32'h2);
        axi_read(BASE + 32'h08, 0, rd, resp);
        chk("status_empty", rd, 32'h1);
        rx_push(8'h5A);
        acyc(6);
        axi_read(BASE + 32'h04, 0, rd, resp);
        chk("rx_second", rd, 32'h5A);

        // Fill TX (0xA5 already queued) then overflow
        errs = 0;
        for (int i = 1; i < 2048; i++) begin
            axi_write(BASE, i & 32'hFF, 4'hF, 0, 0, resp);
            if (resp != 2'b00) errs++;
        end
        chk("fill_resp_errs", errs, 32'd0);
        axi_read(BASE + 32'h08, 0, rd, resp);
        chk("status_tx_full", rd, 32'h3);
        axi_write(BASE, 32'hEE, 4'hF, 0, 1, resp);
        chk("ovf_bresp", {30'd0, resp}, 32'h2);
        axi_read(BASE + 32'h10, 0, rd, resp);
        chk("irq_stat_ovf", rd, 32'h9);
        #1;
        chk("tx_head_kept", {24'd0, tx_rdata}, 32'hA5);
        tx_pop();
        chk("tx_pop1", {24'd0, tx_rdata}, 32'h01);
        tx_pop();
        chk("tx_pop2", {24'd0, tx_rdata}, 32'h02);

        // Decode errors with held response
        axi_read(BASE + 32'h1C, 5, rd, resp);
        chk("decerr_rresp", {30'd0, resp}, 32'h3);
        chk("decerr_rdata", rd, 32'h0);
        axi_write(32'h5000_0000, 32'h1, 4'hF, 5, 1, resp);
        chk("decerr_bresp", {30'd0, resp}, 32'h3);
        axi_read(BASE + 32'h00, 0, rd, resp);
        chk("rd_txdata_slverr", {30'd0, resp}, 32'h2);
        axi_read(BASE + 32'h14, 0, rd, resp);
`ifdef AXI_FIFO_BRIDGE_CNT_EN
        chk("txcnt", rd, 32'd2048);
`else
        chk("cnt_decerr", {30'd0, resp}, 32'h3);
`endif

        // Reset during W_RESP abandons the response
        s_awaddr = BASE + 32'h0C; s_wdata = 32'h3; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1;
        for (int n = 0; n < 20 && !s_awready; n++) begin @(posedge aclk); #1; end
        @(posedge aclk); #1;
        s_awvalid = 0; s_wvalid = 0;
        chk("pre_rst_bvalid", {31'd0, s_bvalid}, 32'd1);
        aresetn = 0;
        #1;
        chk("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
        acyc(2);
        aresetn = 1;
        acyc(2);
        axi_read(BASE + 32'h0C, 0, rd, resp);
        chk("irq_en_after_rst", rd, 32'h0);
        axi_write(BASE + 32'h0C, 32'h5, 4'hF, 0, 1, resp);
        chk("post_rst_bresp", {30'd0, resp}, 32'h0);
        axi_read(BASE + 32'h0C, 0, rd, resp);
        chk("post_rst_irq_en", rd, 32'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
